// File: rtl/hazard_pkg.sv
// Shared types for the hazard controller.
// Shadow stage record, forward select encoding, bubble constant.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  localparam logic [1:0] RESULT_LOAD = 2'b01;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  // x0 never matches; the stage must actually write rd
  function automatic logic rs_match(
    input logic [4:0] rs,
    input stage_rec_t s
  );
    return (rs != 5'd0) && (rs == s.rd) && s.regwrite;
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage record.
// Async clear to BUBBLE, synchronous bubble insert.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bubble,
  input  stage_rec_t d,
  output stage_rec_t q
);

  // Advance the record, or load a bubble when squashed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      q <= BUBBLE;
    else if (bubble)
      q <= BUBBLE;
    else
      q <= d;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, forward selects.
// HAZARD_FORWARD_EN selects forwarding; otherwise stall on any RAW.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       RdD,
  input  logic             RegWriteD,
  input  logic [1:0]       ResultSrcD,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic [CNT_W-1:0] stall_cnt
);

  stage_rec_t d_rec;
  stage_rec_t e_q;
  stage_rec_t m_q;
  stage_rec_t w_q;
  logic       hz;
  fwd_sel_t   fa;
  fwd_sel_t   fb;

  logic [WIDTH-1:0] unused_w;
  logic             unused_bits;

  assign unused_w    = '0;
  assign unused_bits = ^{e_q.rs1, e_q.rs2, e_q.is_load,
                         m_q.rs1, m_q.rs2, m_q.is_load,
                         w_q.rs1, w_q.rs2, w_q.is_load};

  assign d_rec = '{
    rs1:      Rs1D,
    rs2:      Rs2D,
    rd:       RdD,
    regwrite: RegWriteD,
    is_load:  (ResultSrcD == RESULT_LOAD)
  };

  hazard_stage_reg u_e (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (FlushE),
    .d      (d_rec),
    .q      (e_q)
  );

  hazard_stage_reg u_m (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (e_q),
    .q      (m_q)
  );

  hazard_stage_reg u_w (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (1'b0),
    .d      (m_q),
    .q      (w_q)
  );

`ifdef HAZARD_FORWARD_EN
  // Load-use detect and M-over-W forward priority
  always_comb begin
    hz = e_q.is_load &&
         (rs_match(Rs1D, e_q) || rs_match(Rs2D, e_q));
    fa = FWD_REG;
    fb = FWD_REG;
    priority case (1'b1)
      rs_match(e_q.rs1, m_q): fa = FWD_M;
      rs_match(e_q.rs1, w_q): fa = FWD_W;
      default:                fa = FWD_REG;
    endcase
    priority case (1'b1)
      rs_match(e_q.rs2, m_q): fb = FWD_M;
      rs_match(e_q.rs2, w_q): fb = FWD_W;
      default:                fb = FWD_REG;
    endcase
  end
`else
  // No bypass: any in-flight writer of a source stalls Decode
  always_comb begin
    hz = rs_match(Rs1D, e_q) || rs_match(Rs2D, e_q) ||
         rs_match(Rs1D, m_q) || rs_match(Rs2D, m_q) ||
         rs_match(Rs1D, w_q) || rs_match(Rs2D, w_q);
    fa = FWD_REG;
    fb = FWD_REG;
  end
`endif

  // Flush beats stall: the Decode instruction is being discarded
  always_comb begin
    StallF    = hz && !PCSrcE;
    StallD    = hz && !PCSrcE;
    FlushD    = PCSrcE;
    FlushE    = hz || PCSrcE;
    ForwardAE = fa;
    ForwardBE = fb;
  end

  // Saturating count of Decode stall cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (StallD && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: table vectors, corner sequences,
// random stimulus against a queue-based pipeline model.
module tb_hazard_ctrl;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic [4:0]    Rs1D, Rs2D, RdD;
  logic          RegWriteD;
  logic [1:0]    ResultSrcD;
  logic          PCSrcE;
  logic          StallF, StallD, FlushD, FlushE;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] stall_cnt;

  hazard_ctrl #(.WIDTH(32), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .RdD        (RdD),
    .RegWriteD  (RegWriteD),
    .ResultSrcD (ResultSrcD),
    .PCSrcE     (PCSrcE),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .stall_cnt  (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int rs1, rs2, rd;
    bit wr;
    int src;
    bit pc;
    bit sd, fd, fe;
    int fa, fb;
  } vec_t;

  typedef struct {
    int rs1, rs2, rd;
    bit wr, ld;
  } ins_t;

  int   n_run;
  int   n_fail;
  ins_t pipe[$];
  int   m_cnt;
  bit   x_st, x_fd, x_fe;
  int   x_fa, x_fb;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(int rs1, int rs2, int rd, bit wr,
                              int src, bit pc, bit sd, bit fd,
                              bit fe, int fa, int fb);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wr = wr;
    v.src = src; v.pc = pc; v.sd = sd; v.fd = fd; v.fe = fe;
    v.fa = fa; v.fb = fb;
    return v;
  endfunction

  function automatic bit hit(int rs, ins_t s);
    return rs != 0 && s.wr && s.rd == rs;
  endfunction

  task automatic model_reset();
    ins_t b;
    b = '{0, 0, 0, 1'b0, 1'b0};
    pipe = {b, b, b};
    m_cnt = 0;
  endtask

  // pipe[0]=E, pipe[1]=M, pipe[2]=W; newest producer wins
  function automatic int fsel(int rs);
    if (!FWD) return 0;
    for (int k = 1; k <= 2; k++)
      if (hit(rs, pipe[k])) return (k == 1) ? 2 : 1;
    return 0;
  endfunction

  task automatic model_eval(vec_t v);
    bit haz;
    haz = 1'b0;
    if (FWD) begin
      haz = pipe[0].ld && (hit(v.rs1, pipe[0]) || hit(v.rs2, pipe[0]));
    end else begin
      for (int k = 0; k < 3; k++)
        if (hit(v.rs1, pipe[k]) || hit(v.rs2, pipe[k])) haz = 1'b1;
    end
    x_st = haz && !v.pc;
    x_fd = v.pc;
    x_fe = haz || v.pc;
    x_fa = fsel(pipe[0].rs1);
    x_fb = fsel(pipe[0].rs2);
  endtask

  task automatic model_adv(vec_t v);
    ins_t n;
    if (x_fe) n = '{0, 0, 0, 1'b0, 1'b0};
    else n = '{v.rs1, v.rs2, v.rd, v.wr, (v.src == 1)};
    void'(pipe.pop_back());
    pipe.push_front(n);
    if (x_st && m_cnt < CMAX) m_cnt++;
  endtask

  task automatic drive(vec_t v);
    Rs1D = v.rs1[4:0];
    Rs2D = v.rs2[4:0];
    RdD = v.rd[4:0];
    RegWriteD = v.wr;
    ResultSrcD = v.src[1:0];
    PCSrcE = v.pc;
  endtask

  task automatic step(vec_t v, bit use_row, string tag);
    drive(v);
    #1;
    model_eval(v);
    chk({tag, ".StallF"}, StallF, x_st);
    chk({tag, ".StallD"}, StallD, x_st);
    chk({tag, ".FlushD"}, FlushD, x_fd);
    chk({tag, ".FlushE"}, FlushE, x_fe);
    chk({tag, ".FwdA"}, ForwardAE, x_fa);
    chk({tag, ".FwdB"}, ForwardBE, x_fb);
    chk({tag, ".cnt"}, stall_cnt, m_cnt);
    if (use_row) begin
      chk({tag, ".row_stall"}, StallD, v.sd);
      chk({tag, ".row_flushD"}, FlushD, v.fd);
      chk({tag, ".row_flushE"}, FlushE, v.fe);
      chk({tag, ".row_fa"}, ForwardAE, v.fa);
      chk({tag, ".row_fb"}, ForwardBE, v.fb);
    end
    @(posedge clk);
    model_adv(v);
    @(negedge clk);
  endtask

  initial begin
    vec_t v;
    n_run = 0;
    n_fail = 0;
    rst_n = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset.StallD", StallD, 0);
    chk("reset.FlushE", FlushE, 0);
    chk("reset.FwdA", ForwardAE, 0);
    chk("reset.cnt", stall_cnt, 0);
    rst_n = 1'b1;

    if (FWD) begin
      tbl.push_back(mk(0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      tbl.push_back(mk(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(5, 5, 6, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 2, 2));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 1, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end else begin
      tbl.push_back(mk(0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2, 5, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 0, 1, 0, 1, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(5, 7, 6, 1, 0, 1, 0, 1, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    foreach (tbl[i]) step(tbl[i], 1'b1, $sformatf("row%0d", i));
    chk("table.cnt", stall_cnt, FWD ? 1 : 6);

    // reset dropped during a load-use stall
    for (int i = 0; i < 3; i++)
      step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "drain");
    step(mk(0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, "rst_lw");
    v = mk(5, 7, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    #1;
    chk("rst.pre_stall", StallD, 1);
    rst_n = 1'b0;
    #1;
    chk("rst.StallF", StallF, 0);
    chk("rst.StallD", StallD, 0);
    chk("rst.FlushD", FlushD, 0);
    chk("rst.FlushE", FlushE, 0);
    chk("rst.FwdA", ForwardAE, 0);
    chk("rst.FwdB", ForwardBE, 0);
    chk("rst.cnt", stall_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(v, 1'b0, "rst_post");
    chk("rst.post_cnt", stall_cnt, 0);

    // random traffic on a small register set to provoke hazards
    for (int i = 0; i < 400; i++) begin
      v = mk($urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
             0, 0, 0, 0, 0);
      step(v, 1'b0, $sformatf("rnd%0d", i));
    end

    // repeated load-use pairs drive the counter into saturation
    for (int i = 0; i < 20; i++) begin
      step(mk(0, 0, 5, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, "sat_lw");
      step(mk(5, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, "sat_use");
    end
    chk("sat.cnt", stall_cnt, CMAX);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
